// File: rtl/bist_ctrl_if.sv
// bist_ctrl_if: BIST sequencer handshake and signature bundle.
//   Parameter SIG_W: signature width.
//   start, abort   run request / cancel, from the requester
//   sig_in         signature from the compactor (SISR)
//   seed_ld        one-cycle seed load for LFSR, clear for SISR
//   run_en         shift enable for LFSR and SISR
//   busy, done     run in progress / result valid (held)
//   pass           captured signature matched the golden value
//   sig_cap        captured signature, only when BIST_SIG_OUT_EN is defined
//   modport slave is the controller side, modport master the requester side.
interface bist_ctrl_if #(parameter int SIG_W = 4);
   logic start;
   logic abort;
   logic [SIG_W-1:0] sig_in;
   logic seed_ld;
   logic run_en;
   logic busy;
   logic done;
   logic pass;
`ifdef BIST_SIG_OUT_EN
   logic [SIG_W-1:0] sig_cap;
   modport slave (input start, abort, sig_in, output seed_ld, run_en, busy, done, pass, sig_cap);
   modport master (output start, abort, sig_in, input seed_ld, run_en, busy, done, pass, sig_cap);
`else
   modport slave (input start, abort, sig_in, output seed_ld, run_en, busy, done, pass);
   modport master (output start, abort, sig_in, input seed_ld, run_en, busy, done, pass);
`endif
endinterface

// File: rtl/bist_ctrl.sv
// bist_ctrl: BIST sequencer - seeds LFSR/SISR, runs N_PAT patterns, settles, checks signature.
//   clk    system clock, rising edge
//   rst_b  asynchronous reset, active low
//   bus    bist_ctrl_if.slave: start/abort/sig_in in; seed_ld/run_en/busy/done/pass out
//   Optional macro BIST_SIG_OUT_EN adds the registered sig_cap output.
//   All outputs are registered from the next state, so none depends combinationally on inputs.
module bist_ctrl #(
   parameter int N_PAT = 31,
   parameter int CNT_W = 5,
   parameter int SIG_W = 4,
   parameter logic [SIG_W-1:0] GOLDEN = 4'hA
) (
   input logic clk,
   input logic rst_b,
   bist_ctrl_if.slave bus
);
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] SEED = 3'd1;
   localparam logic [2:0] RUN = 3'd2;
   localparam logic [2:0] SETTLE = 3'd3;
   localparam logic [2:0] DONE = 3'd4;
   logic [2:0] state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic seed_ld, run_en, busy, done, pass;
   logic in_run, last;
   assign in_run = (state == SEED) || (state == RUN) || (state == SETTLE);
   assign last = cnt == CNT_W'(N_PAT - 1);
   // abort outranks every transition; start is only heard in IDLE/DONE
   always_comb begin
      state_nx = (in_run && bus.abort) ? IDLE :
                 (state == IDLE || state == DONE) ? (bus.start ? SEED : state) :
                 (state == SEED) ? RUN :
                 (state == RUN) ? (last ? SETTLE : RUN) :
                 (state == SETTLE) ? DONE : IDLE;
   end
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= IDLE;
         cnt <= '0;
         seed_ld <= 1'b0;
         run_en <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         pass <= 1'b0;
      end else begin
         state <= state_nx;
         cnt <= (state == RUN) ? cnt + 1'b1 : '0;
         seed_ld <= state_nx == SEED;
         run_en <= state_nx == RUN;
         busy <= (state_nx == SEED) || (state_nx == RUN) || (state_nx == SETTLE);
         done <= state_nx == DONE;
         // capture on SETTLE->DONE, hold in DONE, clear on restart/abort
         pass <= (state_nx != DONE) ? 1'b0 : (state == SETTLE) ? (bus.sig_in == GOLDEN) : pass;
      end
   end
   assign bus.seed_ld = seed_ld;
   assign bus.run_en = run_en;
   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.pass = pass;
`ifdef BIST_SIG_OUT_EN
   logic [SIG_W-1:0] sig_cap;
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) sig_cap <= '0;
      else sig_cap <= (state_nx != DONE) ? '0 : (state == SETTLE) ? bus.sig_in : sig_cap;
   end
   assign bus.sig_cap = sig_cap;
`endif
endmodule

// File: tb/tb_bist_ctrl.sv
// tb_bist_ctrl: directed self-checking bench for bist_ctrl (default and N_PAT=1 instances).
module tb_bist_ctrl;
   logic clk = 1'b0;
   logic rst_b = 1'b0;
   int n_chk = 0;
   int n_err = 0;
   bist_ctrl_if #(.SIG_W(4)) bus ();
   bist_ctrl_if #(.SIG_W(4)) bus1 ();
   bist_ctrl dut (.clk(clk), .rst_b(rst_b), .bus(bus));
   bist_ctrl #(.N_PAT(1)) dut1 (.clk(clk), .rst_b(rst_b), .bus(bus1));
   logic [4:0] outs, outs1;
   assign outs = {bus.seed_ld, bus.run_en, bus.busy, bus.done, bus.pass};
   assign outs1 = {bus1.seed_ld, bus1.run_en, bus1.busy, bus1.done, bus1.pass};
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // start a run; sig goes on sig_in only during SETTLE, its inverse otherwise
   task automatic do_run(input logic [3:0] sig, input int start_at, input logic exp_pass);
      int k, seeds, runs;
      k = 0;
      seeds = 0;
      runs = 0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("start_done_drop", {27'd0, outs}, {27'd0, 5'b10100});
      while (!bus.done && k < 60) begin
         seeds += int'(bus.seed_ld);
         runs += int'(bus.run_en);
         bus.sig_in = (bus.busy && !bus.run_en && !bus.seed_ld) ? sig : ~sig;
         bus.start = (k == start_at);
         tick();
         k++;
      end
      bus.start = 1'b0;
      chk("seed_cycles", seeds, 1);
      chk("run_cycles", runs, 31);
      chk("latency", k, 33);
      chk("done_pass", {30'd0, bus.busy, bus.done, bus.pass}, {30'd0, 1'b0, 1'b1, exp_pass});
`ifdef BIST_SIG_OUT_EN
      chk("sig_cap", bus.sig_cap, sig);
`endif
   endtask

   task automatic abort_at(input int at);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.sig_in = 4'hA;
      repeat (at) tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("abort_outs", outs, 0);
      tick();
      chk("abort_idle", outs, 0);
   endtask

   initial begin
      int held;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.sig_in = '0;
      bus1.start = 1'b0;
      bus1.abort = 1'b0;
      bus1.sig_in = '0;
      #20;
      chk("reset_outs", outs, 0);
      #5 rst_b = 1'b1;
      repeat (10) begin
         tick();
         chk("idle_outs", outs, 0);
      end
`ifdef BIST_SIG_OUT_EN
      chk("idle_sig_cap", bus.sig_cap, 0);
`endif
      do_run(4'hA, -1, 1'b1);
      do_run(4'h5, -1, 1'b0);
      bus.abort = 1'b1;
      held = 0;
      repeat (20) begin
         tick();
         held += int'(bus.done && !bus.pass);
      end
      bus.abort = 1'b0;
      chk("fail_hold", held, 20);
      do_run(4'hA, 11, 1'b1);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chk("start_over_abort", outs, 5'b10100);
      repeat (16) tick();
      chk("run_cycle15", outs, 5'b01100);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("abort_run", outs, 0);
      abort_at(32);
      do_run(4'hA, -1, 1'b1);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (10) tick();
      #2 rst_b = 1'b0;
      #1 chk("async_rst", outs, 0);
      @(negedge clk) rst_b = 1'b1;
      tick();
      chk("post_rst_idle", outs, 0);
      do_run(4'hC, -1, 1'b0);
      bus1.start = 1'b1;
      tick();
      bus1.start = 1'b0;
      chk("n1_seed", outs1, 5'b10100);
      tick();
      chk("n1_run", outs1, 5'b01100);
      tick();
      chk("n1_settle", outs1, 5'b00100);
      bus1.sig_in = 4'hA;
      tick();
      chk("n1_done", outs1, 5'b00011);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/bist_ctrl.md
Name: bist_ctrl

Overview:
- Sequencer and response evaluator for the on-chip BIST loop: pattern generator, then CUT, then signature register.
- On a start request it seeds the generator and compactor, enables them for a fixed number of patterns, and waits one settle cycle.
- It then captures the compacted signature, compares it against a golden value, and reports done/pass with a level handshake.
- It sits above the LFSR/SISR pair and drives their enables; it is the consumer end of the signature interface.

Parameters:
- N_PAT, 31, number of patterns applied per run (31 = full period of the 5-bit LFSR); legal range 1..2^CNT_W-1.
- CNT_W, 5, width of the pattern counter.
- SIG_W, 4, signature width.
- GOLDEN, 4'hA, expected fault-free signature; overridden per CUT at integration.

Ports:
- clk      input   1       system clock, rising edge.
- rst_b    input   1       asynchronous reset, active low.
- start    input   1       run request, sampled on clk; honoured only in IDLE or DONE.
- abort    input   1       cancels a run in progress.
- sig_in   input   SIG_W   signature from the compactor.
- seed_ld  output  1       one-cycle pulse: LFSR loads its seed, SISR clears.
- run_en   output  1       shift enable for LFSR and SISR.
- busy     output  1       run in progress.
- done     output  1       result valid, held.
- pass     output  1       sig_in matched GOLDEN at capture; meaningful only while done=1.

Behaviour:
- All outputs are registered (Moore); no combinational path from inputs to outputs.
- Reset (rst_b=0, asynchronous):
  - state=IDLE, cnt=0, sig_cap=0.
  - seed_ld=0, run_en=0, busy=0, done=0, pass=0.
- States: IDLE, SEED, RUN, SETTLE, DONE.
- IDLE: all outputs 0. start=1 at edge e0 -> SEED.
- SEED: seed_ld=1, busy=1, run_en=0; lasts exactly 1 cycle -> RUN; cnt<=0.
- RUN:
  - run_en=1, busy=1; cnt increments every cycle.
  - When cnt==N_PAT-1 -> SETTLE. run_en is high for exactly N_PAT cycles (edges e2..e(1+N_PAT)).
- SETTLE:
  - run_en=0, busy=1; lasts 1 cycle so the SISR absorbs the last response.
  - On the leaving edge e(2+N_PAT): sig_cap<=sig_in, pass<=(sig_in==GOLDEN), done<=1, busy<=0 -> DONE.
- DONE:
  - done=1; pass and sig_cap held.
  - start=1 -> SEED, with done<=0 and pass<=0 on the same edge (restart).
  - Otherwise stay in DONE.
- Latency: done rises on edge e(2+N_PAT) after the start edge e0, i.e. 33 cycles for N_PAT=31.
- start while busy (SEED/RUN/SETTLE): ignored, with no effect on cnt.
- abort=1 in SEED/RUN/SETTLE:
  - next edge -> IDLE; run_en=0, busy=0, done=0, pass=0.
  - abort takes priority over every transition, including SETTLE->DONE.
- abort in IDLE/DONE: ignored; the DONE result is preserved.
- start and abort both high in DONE: start wins (abort is ignored outside busy states).
- Reset mid-run: immediate return to IDLE regardless of state; no partial result is reported.
- cnt never wraps. N_PAT=1 gives one RUN cycle.

Optional Feature:
- Macro: BIST_SIG_OUT_EN.
- Defined:
  - Adds output sig_cap [SIG_W-1:0], the captured signature, valid while done=1.
  - Reset value 0; cleared on restart and on abort.
- Undefined:
  - Port and register absent; pass is computed directly from sig_in on the capture edge.
  - All other behaviour is identical.

Test Plan:
- Reset then idle: rst_b low 25 ns, no start -> all outputs 0 for 10 cycles.
- Nominal pass: pulse start, bench drives sig_in=4'hA during SETTLE ->
  - seed_ld high exactly 1 cycle;
  - run_en high exactly 31 cycles;
  - done=1 and pass=1 on edge 33 after start;
  - sig_cap=4'hA (with BIST_SIG_OUT_EN).
- Fail: same run with sig_in=4'h5 -> done=1, pass=0; result held 20 cycles with start=0.
- Start while busy: pulse start at RUN cycle 10 -> run_en still exactly 31 cycles; done timing unchanged.
- Abort: abort=1 at RUN cycle 15 -> next cycle busy=0, run_en=0, done=0, state IDLE. A fresh start then completes normally.
- Restart and async reset:
  - start in DONE -> done drops on the same edge, new seed_ld pulse follows.
  - rst_b low mid-RUN, between edges -> outputs 0 immediately, without waiting for clk.
